// File: rtl/cpu_pkg.sv
// Shared core definitions: architectural sizes, common types and the write-select legality check.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0]      regaddr_t;
  typedef logic [XLEN-1:0] word_t;

  // True when exactly one bit is set; shared with the address-decoder bench.
  function automatic logic is_onehot(input logic [NREGS-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < NREGS; i++) begin
      cnt += int'(vec[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/reg_word.sv
// One WIDTH-bit architectural register with load enable and asynchronous active-low clear.
module reg_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file: one-hot clocked write port, two combinational read ports, x0 hardwired to zero.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [DEPTH-1:0]         wsel,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  input  logic [$clog2(DEPTH)-1:0] raddr2,
  output logic [WIDTH-1:0]         rdata1,
  output logic [WIDTH-1:0]         rdata2,
  output logic [DEPTH-1:0]         written,
  output logic                     sel_err
);

  // The shared legality check is sized for NREGS; DEPTH must not exceed it.
  logic [NREGS-1:0] sel_ext;
  logic             sel_ok;
  logic [DEPTH-1:0] wr_mask;
  logic [WIDTH-1:0] regs [DEPTH];

  assign sel_ext = NREGS'(wsel);
  assign sel_ok  = is_onehot(sel_ext);
  // Bit 0 is masked off so a legal write to x0 is silently dropped.
  assign wr_mask = (we && sel_ok) ? {wsel[DEPTH-1:1], 1'b0} : '0;

  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (wr_mask[i]),
      .d    (wdata),
      .q    (regs[i])
    );
  end

  // No write-to-read bypass: a same-cycle read returns the old value.
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
      sel_err <= 1'b0;
    end else begin
      written <= written | wr_mask;
      if (we && !sel_ok) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a vector table plus hand-written reset, same-cycle-read and sticky-error sequences.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] written;
  logic        sel_err;

  int total = 0;
  int bad   = 0;

  reg_file #(.DEPTH(32), .WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .wsel   (wsel),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .written(written),
    .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] wsel;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ew;
    logic        ee;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] s, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2);
    we = w; wsel = s; wdata = d; raddr1 = a1; raddr2 = a2;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  5'd0, 32'h0,         32'h0,         32'h0000_0020, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h0000_0011, 5'd3,  5'd5, 32'h11,        32'hDEAD_BEEF, 32'h0000_0028, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0080, 32'h0000_0022, 5'd3,  5'd7, 32'h11,        32'h22,        32'h0000_00A8, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0080, 32'h0000_0099, 5'd7,  5'd7, 32'h22,        32'h22,        32'h0000_00A8, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0002, 32'h0000_0001, 5'd1,  5'd2, 32'h1,         32'h0,         32'h0000_00AA, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0004, 32'h0000_0002, 5'd1,  5'd2, 32'h1,         32'h2,         32'h0000_00AE, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0006, 32'h0000_00AA, 5'd1,  5'd2, 32'h1,         32'h2,         32'h0000_00AE, 1'b1};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 5'd31, 5'd0, 32'hCAFE_F00D, 32'h0,         32'h8000_00AE, 1'b1};
    vecs[8] = '{1'b0, 32'h0000_0006, 32'h0000_0000, 5'd1,  5'd2, 32'h1,         32'h2,         32'h8000_00AE, 1'b1};

    // Reset with no clock edge yet
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    for (int a = 0; a < 32; a += 7) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #0.1;
      check("reset_rdata1", rdata1, 32'h0);
      check("reset_rdata2", rdata2, 32'h0);
    end
    check("reset_written", written, 32'h0);
    check("reset_sel_err", 32'(sel_err), 32'h0);
    #6 rst_n = 1'b1;

    // Basic write, same-cycle read sees old value
    @(negedge clk);
    drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd0);
    #1;
    check("same_cycle_old", rdata1, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 5'd5, 5'd0);
    check("basic_write", rdata1, 32'hDEAD_BEEF);
    check("basic_written5", 32'(written[5]), 32'h1);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].wsel, vecs[i].wdata, vecs[i].ra1, vecs[i].ra2);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, vecs[i].ra1, vecs[i].ra2);
      check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].e1);
      check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].e2);
      check($sformatf("vec%0d_written", i), written, vecs[i].ew);
      check($sformatf("vec%0d_sel_err", i), 32'(sel_err), 32'(vecs[i].ee));
    end

    // Sticky error across idle cycles
    repeat (10) @(negedge clk);
    check("sel_err_sticky", 32'(sel_err), 32'h1);

    // Zero-bit select after reset
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    check("reset2_sel_err", 32'(sel_err), 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0002, 32'h0000_0005, 5'd1, 5'd2);
    @(negedge clk);
    drive(1'b1, 32'h0000_0000, 32'h0000_00AA, 5'd1, 5'd2);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
    check("zero_sel_x1", rdata1, 32'h5);
    check("zero_sel_x2", rdata2, 32'h0);
    check("zero_sel_err", 32'(sel_err), 32'h1);
    check("zero_sel_written", written, 32'h0000_0002);

    // Reset asserted during a write cycle
    drive(1'b1, 32'h0000_0200, 32'h0000_0055, 5'd9, 5'd9);
    @(negedge clk);
    check("x9_before_rst", rdata1, 32'h55);
    drive(1'b1, 32'h0000_0200, 32'h0000_0077, 5'd9, 5'd9);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_x9", rdata1, 32'h0);
    check("midrst_written", written, 32'h0);
    check("midrst_sel_err", 32'(sel_err), 32'h0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_write_lost", rdata2, 32'h0);
    drive(1'b1, 32'h0000_0200, 32'h0000_0066, 5'd9, 5'd9);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 5'd9, 5'd9);
    check("post_rst_write", rdata1, 32'h66);
    check("post_rst_written", written, 32'h0000_0200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
